// File: rtl/cpu_defs.sv
// Shared CPU definitions: bus widths, arbiter state encoding and the
// request record latched for each side of the unified memory port.
package cpu_defs;

    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned STRB_W = DATA_W / 8;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_D_REQ  = 3'd1,
        ST_D_WAIT = 3'd2,
        ST_I_REQ  = 3'd3,
        ST_I_WAIT = 3'd4,
        ST_DONE   = 3'd5
    } arb_state_e;

    typedef struct packed {
        logic              wr;
        logic [STRB_W-1:0] wstrb;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } mem_req_t;

endpackage

// File: rtl/mem_port_arbiter.sv
// Shares one req/addr_ok/data_ok memory port between instruction fetch and
// data access; data goes first, and the pipeline stalls until both finish.
module mem_port_arbiter
    import cpu_defs::*;
(
    input  logic              clk,
    input  logic              resetn,
    input  logic              inst_en,
    input  logic [ADDR_W-1:0] inst_addr,
    output logic [DATA_W-1:0] inst_rdata,
    input  logic              data_en,
    input  logic [STRB_W-1:0] data_wen,
    input  logic [ADDR_W-1:0] data_addr,
    input  logic [DATA_W-1:0] data_wdata,
    output logic [DATA_W-1:0] data_rdata,
    output logic              stallreq,
    output logic              mem_req,
    output logic              mem_wr,
    output logic [STRB_W-1:0] mem_wstrb,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_addr_ok,
    input  logic              mem_data_ok,
    input  logic [DATA_W-1:0] mem_rdata
);

    arb_state_e        r_state;
    logic              r_dpend;
    logic              r_ipend;
    mem_req_t          r_dreq;
    mem_req_t          r_ireq;
    logic [DATA_W-1:0] r_inst_rdata;
    logic [DATA_W-1:0] r_data_rdata;
    logic              w_busy;
    mem_req_t          w_port;

    // Sequencer: latch both requests in IDLE, then serve data before fetch.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state      <= ST_IDLE;
            r_dpend      <= 1'b0;
            r_ipend      <= 1'b0;
            r_dreq       <= '0;
            r_ireq       <= '0;
            r_inst_rdata <= '0;
            r_data_rdata <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_dpend <= data_en;
                    r_ipend <= inst_en;
                    if (data_en) begin
                        r_dreq <= '{wr: |data_wen, wstrb: data_wen,
                                    addr: data_addr, wdata: data_wdata};
                    end
                    if (inst_en) begin
                        r_ireq <= '{wr: 1'b0, wstrb: '0,
                                    addr: inst_addr, wdata: '0};
                    end
                    if (data_en) begin
                        r_state <= ST_D_REQ;
                    end else if (inst_en) begin
                        r_state <= ST_I_REQ;
                    end
                end
                ST_D_REQ: begin
                    if (mem_addr_ok) r_state <= ST_D_WAIT;
                end
                ST_D_WAIT: begin
                    if (mem_data_ok) begin
                        if (!r_dreq.wr) r_data_rdata <= mem_rdata;
                        r_dpend <= 1'b0;
                        r_state <= r_ipend ? ST_I_REQ : ST_DONE;
                    end
                end
                ST_I_REQ: begin
                    if (mem_addr_ok) r_state <= ST_I_WAIT;
                end
                ST_I_WAIT: begin
                    if (mem_data_ok) begin
                        r_inst_rdata <= mem_rdata;
                        r_ipend      <= 1'b0;
                        r_state      <= ST_DONE;
                    end
                end
                ST_DONE: r_state <= ST_IDLE;
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // Port fields follow the record being served; the data record owns the
    // port for as long as its pending flag is set.
    always_comb begin
        w_busy   = 1'b0;
        w_port   = '0;
        mem_req  = 1'b0;
        stallreq = 1'b0;
        case (r_state)
            ST_IDLE:   stallreq = inst_en | data_en;
            ST_D_REQ,
            ST_I_REQ:  begin w_busy = 1'b1; mem_req = 1'b1; stallreq = 1'b1; end
            ST_D_WAIT,
            ST_I_WAIT: begin w_busy = 1'b1; stallreq = 1'b1; end
            default:   stallreq = 1'b0;
        endcase
        if (w_busy) w_port = r_dpend ? r_dreq : r_ireq;
    end

    assign mem_wr     = w_port.wr;
    assign mem_wstrb  = w_port.wstrb;
    assign mem_addr   = w_port.addr;
    assign mem_wdata  = w_port.wdata;
    assign inst_rdata = r_inst_rdata;
    assign data_rdata = r_data_rdata;

endmodule
